// File: rtl/cpu_pkg.sv
// Shared CPU definitions: EX-stage widths, opcode constants and EX->MEM control bundle.
package cpu_pkg;

    localparam int unsigned OPC_W          = 6;
    localparam int unsigned DATA_W_DEFAULT = 32;
    localparam int unsigned REG_AW_DEFAULT = 5;

    // Opcode field is Inst[31:26]; an all-zero opcode is the pipeline bubble.
    localparam logic [OPC_W-1:0] OPC_NOP = '0;

    // Control bits produced by the EX stage alongside each instruction.
    typedef struct packed {
        logic reg_we;
        logic mem_we;
        logic mem_re;
        logic set_flags;
    } ex_ctrl_t;

    // A single instruction may not both read and write memory.
    function automatic logic ctrl_illegal(input logic valid, input ex_ctrl_t ctrl);
        return valid & ctrl.mem_we & ctrl.mem_re;
    endfunction

endpackage

// File: rtl/cc_reg.sv
// Architectural condition-code register (N, Z, V) with load enable.
module cc_reg
    import cpu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic n_in,
    input  logic z_in,
    input  logic v_in,
    output logic flag_n,
    output logic flag_z,
    output logic flag_v
);

    logic [2:0] flags_q;

    // Load flags when enabled; hold otherwise; clear on synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= 3'b000;
        end else if (en) begin
            flags_q <= {n_in, z_in, v_in};
        end
    end

    assign flag_n = flags_q[2];
    assign flag_z = flags_q[1];
    assign flag_v = flags_q[0];

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with bubble insertion, stall, condition codes,
// a forwarding tap back to EX and a sticky illegal-control flag.
module ex_mem_reg #(
    parameter int unsigned DATA_W = cpu_pkg::DATA_W_DEFAULT,
    parameter int unsigned REG_AW = cpu_pkg::REG_AW_DEFAULT,
    parameter int unsigned OPC_W  = cpu_pkg::OPC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic [OPC_W-1:0]  ex_opcode,
    input  logic [DATA_W-1:0] ex_out,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_AW-1:0] ex_dst_reg,
    input  logic              ex_reg_we,
    input  logic              ex_mem_we,
    input  logic              ex_mem_re,
    input  logic              ex_set_flags,
    input  logic              N,
    input  logic              Z,
    input  logic              V,
    output logic              mem_valid,
    output logic [OPC_W-1:0]  mem_opcode,
    output logic [DATA_W-1:0] mem_alu_out,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [REG_AW-1:0] mem_dst_reg,
    output logic              mem_reg_we,
    output logic              mem_mem_we,
    output logic              mem_mem_re,
    output logic              flag_N,
    output logic              flag_Z,
    output logic              flag_V,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_reg,
    output logic [DATA_W-1:0] fwd_data,
    output logic              proto_err
);

    import cpu_pkg::*;

    logic              valid_q;
    logic [OPC_W-1:0]  opcode_q;
    logic [DATA_W-1:0] alu_out_q;
    logic [DATA_W-1:0] store_data_q;
    logic [REG_AW-1:0] dst_reg_q;
    logic              reg_we_q;
    logic              mem_we_q;
    logic              mem_re_q;
    logic              proto_err_q;

    ex_ctrl_t ex_ctrl;
    logic     illegal;
    logic     take;
    logic     capture;
    logic     cc_en;

    // Decode the incoming instruction: an illegal one is squashed to a bubble.
    always_comb begin
        ex_ctrl.reg_we    = ex_reg_we;
        ex_ctrl.mem_we    = ex_mem_we;
        ex_ctrl.mem_re    = ex_mem_re;
        ex_ctrl.set_flags = ex_set_flags;
        illegal = ctrl_illegal(ex_valid, ex_ctrl);
        take    = ex_valid & ~illegal;
        capture = ~flush & ~stall;
        cc_en   = capture & take & ex_ctrl.set_flags;
    end

    // Pipeline state: rst > flush > stall > capture; invalid or illegal capture loads a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            opcode_q     <= OPC_W'(OPC_NOP);
            alu_out_q    <= '0;
            store_data_q <= '0;
            dst_reg_q    <= '0;
            reg_we_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            proto_err_q  <= 1'b0;
        end else if (flush || (capture && !take)) begin
            valid_q      <= 1'b0;
            opcode_q     <= OPC_W'(OPC_NOP);
            alu_out_q    <= '0;
            store_data_q <= '0;
            dst_reg_q    <= '0;
            reg_we_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            if (!flush && illegal) begin
                proto_err_q <= 1'b1;
            end
        end else if (capture) begin
            valid_q      <= 1'b1;
            opcode_q     <= ex_opcode;
            alu_out_q    <= ex_out;
            store_data_q <= ex_store_data;
            dst_reg_q    <= ex_dst_reg;
            // Register 0 is hardwired; never schedule a write to it.
            reg_we_q     <= ex_ctrl.reg_we & (ex_dst_reg != '0);
            mem_we_q     <= ex_ctrl.mem_we;
            mem_re_q     <= ex_ctrl.mem_re;
        end
    end

    cc_reg u_cc_reg (
        .clk    (clk),
        .rst    (rst),
        .en     (cc_en),
        .n_in   (N),
        .z_in   (Z),
        .v_in   (V),
        .flag_n (flag_N),
        .flag_z (flag_Z),
        .flag_v (flag_V)
    );

    // Outputs and forwarding tap; load results are not ready until after MEM.
    always_comb begin
        mem_valid      = valid_q;
        mem_opcode     = opcode_q;
        mem_alu_out    = alu_out_q;
        mem_store_data = store_data_q;
        mem_dst_reg    = dst_reg_q;
        mem_reg_we     = reg_we_q;
        mem_mem_we     = mem_we_q;
        mem_mem_re     = mem_re_q;
        proto_err      = proto_err_q;
        fwd_valid      = valid_q & reg_we_q & ~mem_re_q;
        fwd_reg        = dst_reg_q;
        fwd_data       = alu_out_q;
    end

endmodule
